// File: rtl/decode_stage.sv
// Registered opcode decoder with a 2-entry skid buffer and halt/resume sequencing.
// Optional undefined-opcode trapping is enabled by defining DECODE_STAGE_ILLEGAL_TRAP_EN.
module decode_stage #(
  parameter int OPCODE_W = 5,
  parameter int ARG_W    = 27,
  parameter int NUM_OPS  = 20,
  parameter int HLT_OP   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPCODE_W+ARG_W-1:0] in_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_W-1:0]       out_opcode,
  output logic [ARG_W-1:0]          out_arg,
  output logic [2**OPCODE_W-1:0]    out_onehot,
  output logic                      out_illegal,
  output logic                      halted,
  input  logic                      resume
);

  localparam int WORD_W = OPCODE_W + ARG_W;
  localparam logic [OPCODE_W-1:0] HLT_OP_W = OPCODE_W'(HLT_OP);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                   r_out_valid;
  logic [OPCODE_W-1:0]    r_out_opcode;
  logic [ARG_W-1:0]       r_out_arg;
  logic [2**OPCODE_W-1:0] r_out_onehot;
  logic                   r_out_illegal;
  logic                   r_skid_valid;
  logic [WORD_W-1:0]      r_skid_word;

  logic                   w_accept;
  logic                   w_out_free;
  logic [WORD_W-1:0]      w_load_word;
  logic [OPCODE_W-1:0]    w_load_op;
  logic [OPCODE_W-1:0]    w_in_op;
  logic                   w_load_illegal;
  logic                   w_in_illegal;
  logic [2**OPCODE_W-1:0] w_load_onehot;

  assign in_ready   = !rst && !r_skid_valid && (r_state == ST_RUN);
  assign w_accept   = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Skid entry always precedes a newly accepted word to keep FIFO order.
  assign w_load_word = r_skid_valid ? r_skid_word : in_word;
  assign w_load_op   = w_load_word[WORD_W-1:ARG_W];
  assign w_in_op     = in_word[WORD_W-1:ARG_W];

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  localparam logic [OPCODE_W:0] NUM_OPS_W = (OPCODE_W+1)'(NUM_OPS);
  assign w_load_illegal = ({1'b0, w_load_op} >= NUM_OPS_W);
  assign w_in_illegal   = ({1'b0, w_in_op} >= NUM_OPS_W);
`else
  assign w_load_illegal = 1'b0;
  assign w_in_illegal   = 1'b0;
`endif

  always_comb begin
    w_load_onehot = '0;
    if (!w_load_illegal) w_load_onehot[w_load_op] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_opcode  <= '0;
      r_out_arg     <= '0;
      r_out_onehot  <= '0;
      r_out_illegal <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_word   <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid || w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_opcode  <= w_load_op;
        r_out_arg     <= w_load_word[ARG_W-1:0];
        r_out_onehot  <= w_load_onehot;
        r_out_illegal <= w_load_illegal;
        r_skid_valid  <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_word  <= in_word;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Resume is only honoured outside RUN, so it cannot cancel a halt taken on the same edge.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (w_accept && (w_in_op == HLT_OP_W)) w_state_next = ST_HALT;
        else if (w_accept && w_in_illegal)     w_state_next = ST_TRAP;
      end
      ST_HALT, ST_TRAP: begin
        if (resume) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_out_opcode;
  assign out_arg     = r_out_arg;
  assign out_onehot  = r_out_onehot;
  assign out_illegal = r_out_illegal;
  assign halted      = (r_state != ST_RUN);

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage; expectations follow DECODE_STAGE_ILLEGAL_TRAP_EN when defined.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [26:0] out_arg;
  logic [31:0] out_onehot;
  logic        out_illegal;
  logic        halted;
  logic        resume;

  int n_pass = 0;
  int n_total = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_arg(out_arg), .out_onehot(out_onehot),
    .out_illegal(out_illegal), .halted(halted), .resume(resume)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  op;
    logic [26:0] arg;
    logic        ordy;
    logic        res;
    logic        e_ov;
    logic [4:0]  e_op;
    logic [26:0] e_arg;
    logic [31:0] e_oh;
    logic        e_ill;
    logic        e_hlt;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic iv, input logic [4:0] op, input logic [26:0] arg,
                      input logic ordy, input logic res);
    in_valid  = iv;
    in_word   = {op, arg};
    out_ready = ordy;
    resume    = res;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic [4:0] op, input logic [26:0] arg,
                     input logic ordy, input logic res, input logic e_ov,
                     input logic [4:0] e_op, input logic [26:0] e_arg, input logic [31:0] e_oh,
                     input logic e_ill, input logic e_hlt, input logic e_ir);
    vec_t v;
    v = '{iv, op, arg, ordy, res, e_ov, e_op, e_arg, e_oh, e_ill, e_hlt, e_ir};
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; resume = 1'b0;

    // Each row: inputs during a cycle, expected outputs just after that cycle's edge.
    //   iv op  arg      rdy res | ov op  arg      onehot        ill hlt ir
    add(1, 0,  27'h11,  1, 0,    1, 0,  27'h11,  32'h1,        0,  0,  1); // streaming
    add(1, 2,  27'h22,  1, 0,    1, 2,  27'h22,  32'h4,        0,  0,  1);
    add(1, 3,  27'h33,  1, 0,    1, 3,  27'h33,  32'h8,        0,  0,  1);
    add(0, 0,  27'h0,   1, 0,    0, 0,  27'h0,   32'h0,        0,  0,  1);
    add(1, 4,  27'h44,  0, 0,    1, 4,  27'h44,  32'h10,       0,  0,  1); // backpressure
    add(1, 5,  27'h55,  0, 0,    1, 4,  27'h44,  32'h10,       0,  0,  0);
    add(1, 6,  27'h66,  0, 0,    1, 4,  27'h44,  32'h10,       0,  0,  0);
    add(1, 6,  27'h66,  0, 0,    1, 4,  27'h44,  32'h10,       0,  0,  0);
    add(1, 6,  27'h66,  1, 0,    1, 5,  27'h55,  32'h20,       0,  0,  1);
    add(1, 6,  27'h66,  1, 0,    1, 6,  27'h66,  32'h40,       0,  0,  1);
    add(1, 7,  27'h77,  1, 0,    1, 7,  27'h77,  32'h80,       0,  0,  1);
    add(0, 0,  27'h0,   1, 0,    0, 0,  27'h0,   32'h0,        0,  0,  1);
    add(1, 15, 27'h5,   1, 0,    1, 15, 27'h5,   32'h8000,     0,  1,  0); // halt
    add(1, 2,  27'h2,   1, 0,    0, 0,  27'h0,   32'h0,        0,  1,  0);
    add(1, 2,  27'h2,   1, 1,    0, 0,  27'h0,   32'h0,        0,  0,  1);
    add(1, 2,  27'h2,   1, 0,    1, 2,  27'h2,   32'h4,        0,  0,  1);
    add(0, 0,  27'h0,   1, 0,    0, 0,  27'h0,   32'h0,        0,  0,  1);
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    add(1, 25, 27'h99,  1, 0,    1, 25, 27'h99,  32'h0,        1,  1,  0); // trap
`else
    add(1, 25, 27'h99,  1, 0,    1, 25, 27'h99,  32'h0200_0000, 0, 0,  1);
`endif
    add(0, 0,  27'h0,   1, 1,    0, 0,  27'h0,   32'h0,        0,  0,  1);
    add(1, 15, 27'h1,   1, 1,    1, 15, 27'h1,   32'h8000,     0,  1,  0); // resume ignored in RUN
    add(0, 0,  27'h0,   1, 1,    0, 0,  27'h0,   32'h0,        0,  0,  1);
    add(1, 31, 27'h7ff_ffff, 1, 0,
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
                                 1, 31, 27'h7ff_ffff, 32'h0, 1, 1, 0);
`else
                                 1, 31, 27'h7ff_ffff, 32'h8000_0000, 0, 0, 1);
`endif
    add(0, 0,  27'h0,   1, 1,    0, 0,  27'h0,   32'h0,        0,  0,  1);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_opcode", 64'(out_opcode), 64'd0);
    chk("rst_out_arg", 64'(out_arg), 64'd0);
    chk("rst_out_onehot", 64'(out_onehot), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].op, vecs[i].arg, vecs[i].ordy, vecs[i].res);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].e_hlt));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_opcode", i), 64'(out_opcode), 64'(vecs[i].e_op));
        chk($sformatf("v%0d_arg", i), 64'(out_arg), 64'(vecs[i].e_arg));
        chk($sformatf("v%0d_onehot", i), 64'(out_onehot), 64'(vecs[i].e_oh));
        chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].e_ill));
      end
    end

    // Drain continues while halted: fill both entries, HLT lands in the skid register.
    step(1, 1, 27'h101, 0, 0);
    step(1, 15, 27'h1f, 0, 0);
    chk("drain_halted", 64'(halted), 64'd1);
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    chk("drain_head_op", 64'(out_opcode), 64'd1);
    step(1, 3, 27'h3, 1, 0);
    chk("drain_hlt_valid", 64'(out_valid), 64'd1);
    chk("drain_hlt_op", 64'(out_opcode), 64'd15);
    chk("drain_hlt_arg", 64'(out_arg), 64'h1f);
    step(1, 3, 27'h3, 1, 0);
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_still_halted", 64'(halted), 64'd1);
    step(0, 0, 27'h0, 1, 1);
    chk("drain_resumed", 64'(halted), 64'd0);

    // Reset with both entries full and state HALT.
    step(1, 9, 27'h9, 0, 0);
    step(1, 15, 27'h2, 0, 0);
    chk("pre_rst_halted", 64'(halted), 64'd1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step(0, 0, 27'h0, 0, 0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_halted", 64'(halted), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    step(1, 6, 27'h123, 1, 0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_op", 64'(out_opcode), 64'd6);
    chk("post_rst_onehot", 64'(out_onehot), 64'h40);
    step(0, 0, 27'h0, 1, 0);
    chk("post_rst_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
